// File: rtl/conv_core.sv
// Full linear convolution engine. Streams X and Y out of their input RAMs
// (registered read ports) and writes Z[k] = sum X[i]*Y[k-i] to the Z RAM.
module conv_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_X     = 5,
  parameter int unsigned ADDR_Y     = 5,
  parameter int unsigned ADDR_Z     = 6,
  parameter int unsigned ACC_WIDTH  = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_X:0]       size_x_i,
  input  logic [ADDR_Y:0]       size_y_i,
  output logic [ADDR_X-1:0]     memX_addr_o,
  input  logic [DATA_WIDTH-1:0] memX_data_i,
  output logic [ADDR_Y-1:0]     memY_addr_o,
  input  logic [DATA_WIDTH-1:0] memY_data_i,
  output logic                  memZ_we_o,
  output logic [ADDR_Z-1:0]     memZ_addr_o,
  output logic [ACC_WIDTH-1:0]  memZ_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // Common width for index arithmetic; wide enough for k+1 and Nx+Ny.
  localparam int unsigned CW = ADDR_Z + 2;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StInit  = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [ADDR_X:0] MaxNx = {1'b1, {ADDR_X{1'b0}}};
  localparam logic [ADDR_Y:0] MaxNy = {1'b1, {ADDR_Y{1'b0}}};

  logic [2:0]            state_q, state_d;
  logic [ADDR_X:0]       nx_q, nx_d;
  logic [ADDR_Y:0]       ny_q, ny_d;
  logic [ADDR_Z-1:0]     k_q, k_d;
  logic [ADDR_X-1:0]     i_q, i_d;
  logic [ADDR_X-1:0]     hi_q, hi_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  first_q, first_d;
  logic [ADDR_X-1:0]     x_addr_q, x_addr_d;
  logic [ADDR_Y-1:0]     y_addr_q, y_addr_d;
  logic [ADDR_Z-1:0]     z_addr_q, z_addr_d;
  logic [ACC_WIDTH-1:0]  z_data_q, z_data_d;

  logic [ADDR_X:0]       nx_clamp;
  logic [ADDR_Y:0]       ny_clamp;
  logic [CW-1:0]         k_ext, k_plus1, lo_w, hi_w, last_k;
  logic [PW-1:0]         prod;
  logic [ACC_WIDTH-1:0]  acc_sum;

  // Index bounds and datapath helpers for the current output k.
  always_comb begin
    nx_clamp = (size_x_i > MaxNx) ? MaxNx : size_x_i;
    ny_clamp = (size_y_i > MaxNy) ? MaxNy : size_y_i;
    k_ext    = CW'(k_q);
    k_plus1  = k_ext + CW'(1);
    lo_w     = (k_plus1 > CW'(ny_q)) ? (k_plus1 - CW'(ny_q)) : '0;
    hi_w     = (k_ext < (CW'(nx_q) - CW'(1))) ? k_ext : (CW'(nx_q) - CW'(1));
    last_k   = CW'(nx_q) + CW'(ny_q) - CW'(2);
    prod     = PW'(memX_data_i) * PW'(memY_data_i);
    acc_sum  = acc_q + ACC_WIDTH'(prod);
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    nx_d     = nx_q;
    ny_d     = ny_q;
    k_d      = k_q;
    i_d      = i_q;
    hi_d     = hi_q;
    acc_d    = acc_q;
    first_d  = first_q;
    x_addr_d = x_addr_q;
    y_addr_d = y_addr_q;
    z_addr_d = z_addr_q;
    z_data_d = z_data_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          nx_d    = nx_clamp;
          ny_d    = ny_clamp;
          k_d     = '0;
          state_d = ((nx_clamp == '0) || (ny_clamp == '0)) ? StDone : StInit;
        end
      end
      StInit: begin
        acc_d    = '0;
        first_d  = 1'b1;
        i_d      = ADDR_X'(lo_w);
        hi_d     = ADDR_X'(hi_w);
        x_addr_d = ADDR_X'(lo_w);
        y_addr_d = ADDR_Y'(k_ext - lo_w);
        state_d  = StRead;
      end
      StRead: begin
        first_d = 1'b0;
        // RAM data lags the address by one cycle, so the first READ has nothing to add.
        if (!first_q) acc_d = acc_sum;
        if (i_q == hi_q) begin
          state_d = StDrain;
        end else begin
          i_d      = i_q + ADDR_X'(1);
          x_addr_d = i_q + ADDR_X'(1);
          y_addr_d = ADDR_Y'(k_ext - CW'(i_q) - CW'(1));
        end
      end
      StDrain: begin
        acc_d    = acc_sum;
        z_data_d = acc_sum;
        z_addr_d = k_q;
        state_d  = StWrite;
      end
      StWrite: begin
        if (k_ext == last_k) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + ADDR_Z'(1);
          state_d = StInit;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; asynchronous reset clears everything, outputs included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      nx_q     <= '0;
      ny_q     <= '0;
      k_q      <= '0;
      i_q      <= '0;
      hi_q     <= '0;
      acc_q    <= '0;
      first_q  <= 1'b0;
      x_addr_q <= '0;
      y_addr_q <= '0;
      z_addr_q <= '0;
      z_data_q <= '0;
    end else begin
      state_q  <= state_d;
      nx_q     <= nx_d;
      ny_q     <= ny_d;
      k_q      <= k_d;
      i_q      <= i_d;
      hi_q     <= hi_d;
      acc_q    <= acc_d;
      first_q  <= first_d;
      x_addr_q <= x_addr_d;
      y_addr_q <= y_addr_d;
      z_addr_q <= z_addr_d;
      z_data_q <= z_data_d;
    end
  end

  // Outputs: addresses and write data are registered and hold between updates.
  always_comb begin
    memX_addr_o = x_addr_q;
    memY_addr_o = y_addr_q;
    memZ_addr_o = z_addr_q;
    memZ_data_o = z_data_q;
    memZ_we_o   = (state_q == StWrite);
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StDone);
  end

endmodule

// File: tb/tb_conv_core.sv
// Scoreboard bench for conv_core: stimulus pushes expected Z writes, a
// negedge monitor pops and compares every Z RAM write the DUT issues.
module tb_conv_core;

  typedef struct packed {
    logic [5:0]  addr;
    logic [20:0] data;
  } zexp_t;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [5:0]  size_x_i;
  logic [5:0]  size_y_i;
  logic [4:0]  memX_addr_o;
  logic [7:0]  memX_data_i;
  logic [4:0]  memY_addr_o;
  logic [7:0]  memY_data_i;
  logic        memZ_we_o;
  logic [5:0]  memZ_addr_o;
  logic [20:0] memZ_data_o;
  logic        busy_o;
  logic        done_o;

  logic [7:0] xmem [32];
  logic [7:0] ymem [32];
  zexp_t      exp_q [$];

  int checks;
  int failures;

  conv_core dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .size_x_i    (size_x_i),
    .size_y_i    (size_y_i),
    .memX_addr_o (memX_addr_o),
    .memX_data_i (memX_data_i),
    .memY_addr_o (memY_addr_o),
    .memY_data_i (memY_data_i),
    .memZ_we_o   (memZ_we_o),
    .memZ_addr_o (memZ_addr_o),
    .memZ_data_o (memZ_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input RAM models with a registered read port.
  always @(posedge clk) begin
    memX_data_i <= xmem[memX_addr_o];
    memY_data_i <= ymem[memY_addr_o];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every Z write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && memZ_we_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL zwrite_unexpected actual_addr=%0d actual_data=%0d expected=none",
                 memZ_addr_o, memZ_data_o);
      end else begin
        zexp_t e;
        e = exp_q.pop_front();
        if (memZ_addr_o !== e.addr || memZ_data_o !== e.data) begin
          failures++;
          $display("FAIL zwrite actual_addr=%0d actual_data=%0d expected_addr=%0d expected_data=%0d",
                   memZ_addr_o, memZ_data_o, e.addr, e.data);
        end
      end
    end
  end

  task automatic push(input int addr, input int data);
    zexp_t e;
    e.addr = 6'(addr);
    e.data = 21'(data);
    exp_q.push_back(e);
  endtask

  // One run: start in an idle cycle, optionally pulse start again at cycle
  // inject_c while busy, then check done timing, busy and write count.
  task automatic run(input string name, input int nx, input int ny, input int exp_done,
                     input int inject_c);
    int c;
    bit busy_ok;
    @(negedge clk);
    chk({name, "_idle_busy"}, 64'(busy_o), 64'd0);
    chk({name, "_idle_done"}, 64'(done_o), 64'd0);
    size_x_i = 6'(nx);
    size_y_i = 6'(ny);
    start_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    c       = 0;
    busy_ok = 1'b1;
    while (!done_o && c < exp_done + 50) begin
      if (!busy_o) busy_ok = 1'b0;
      if (c == inject_c) begin
        start_i  = 1'b1;
        size_x_i = 6'd2;
        size_y_i = 6'd2;
      end else if (c == inject_c + 1) begin
        start_i  = 1'b0;
        size_x_i = 6'(nx);
        size_y_i = 6'(ny);
      end
      @(negedge clk);
      c++;
    end
    start_i = 1'b0;
    if (!busy_o) busy_ok = 1'b0;
    chk({name, "_done_seen"}, 64'(done_o), 64'd1);
    chk({name, "_done_time"}, 64'(c), 64'(exp_done));
    chk({name, "_busy"}, 64'(busy_ok), 64'd1);
    chk({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    bit idle_ok;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start_i  = 1'b0;
    size_x_i = '0;
    size_y_i = '0;
    for (int i = 0; i < 32; i++) begin
      xmem[i] = '0;
      ymem[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_we", 64'(memZ_we_o), 64'd0);
    chk("reset_xaddr", 64'(memX_addr_o), 64'd0);
    chk("reset_zdata", 64'(memZ_data_o), 64'd0);
    rst = 1'b0;

    // Nominal: X=[1,2,3], Y=[1,1] -> [1,3,5,3]
    xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
    ymem[0] = 8'd1; ymem[1] = 8'd1;
    push(0, 1); push(1, 3); push(2, 5); push(3, 3);
    run("nominal", 3, 2, 18, -10);

    // Single sample
    xmem[0] = 8'h07; ymem[0] = 8'h09;
    push(0, 63);
    run("single", 1, 1, 4, -10);

    // Max magnitude: every sample 0xFF
    for (int i = 0; i < 32; i++) begin
      xmem[i] = 8'hFF;
      ymem[i] = 8'hFF;
    end
    for (int k = 0; k < 63; k++) push(k, ((k < 32) ? (k + 1) : (63 - k)) * 65025);
    run("max", 32, 32, 1213, -10);

    // Oversized requests clamp to 32x32
    for (int k = 0; k < 63; k++) push(k, ((k < 32) ? (k + 1) : (63 - k)) * 65025);
    run("clamp", 63, 33, 1213, -10);

    // Asymmetric: X=[5,6,7,8], Y=[2]
    xmem[0] = 8'd5; xmem[1] = 8'd6; xmem[2] = 8'd7; xmem[3] = 8'd8;
    ymem[0] = 8'd2;
    push(0, 10); push(1, 12); push(2, 14); push(3, 16);
    run("asym", 4, 1, 16, -10);

    // Zero size: done right away, no writes
    run("zero", 0, 3, 0, -10);

    // Reset during READ of k=2 in the nominal case
    xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
    ymem[0] = 8'd1; ymem[1] = 8'd1;
    push(0, 1); push(1, 3);
    @(negedge clk);
    size_x_i = 6'd3;
    size_y_i = 6'd2;
    start_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_pre_xaddr", 64'(memX_addr_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_we", 64'(memZ_we_o), 64'd0);
    chk("rst_xaddr", 64'(memX_addr_o), 64'd0);
    chk("rst_yaddr", 64'(memY_addr_o), 64'd0);
    chk("rst_zaddr", 64'(memZ_addr_o), 64'd0);
    chk("rst_zdata", 64'(memZ_data_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (busy_o || done_o) idle_ok = 1'b0;
    end
    chk("rst_stays_idle", 64'(idle_ok), 64'd1);
    chk("rst_writes_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Fresh start after reset
    push(0, 1); push(1, 3); push(2, 5); push(3, 3);
    run("after_rst", 3, 2, 18, -10);

    // Start pulsed while busy is ignored
    push(0, 1); push(1, 3); push(2, 5); push(3, 3);
    run("start_busy", 3, 2, 18, 5);

    // Back-to-back: start in the cycle right after DONE
    xmem[0] = 8'h07; ymem[0] = 8'h09;
    push(0, 63);
    run("b2b", 1, 1, 4, -10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_core.md
Name: conv_core

Overview:
- Convolution engine sitting directly downstream of the X and Y input RAMs in the convolution IP.
- On a start pulse it reads X[0..Nx-1] and Y[0..Ny-1] through their registered read ports and computes the full linear convolution Z[k] = sum X[i]*Y[k-i].
- It writes Z[0..Nx+Ny-2] into the Z result RAM, then pulses done.

Parameters:
- DATA_WIDTH, 8: width of X and Y samples (unsigned).
- ADDR_X, 5: address width of X RAM; max Nx = 2**ADDR_X.
- ADDR_Y, 5: address width of Y RAM; max Ny = 2**ADDR_Y.
- ADDR_Z, 6: address width of Z RAM; must be >= max(ADDR_X,ADDR_Y)+1.
- ACC_WIDTH, 21: accumulator and Z data width; must be >= 2*DATA_WIDTH+min(ADDR_X,ADDR_Y).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  start request, sampled only in IDLE.
- size_x_i  in  ADDR_X+1  Nx, latched at start.
- size_y_i  in  ADDR_Y+1  Ny, latched at start.
- memX_addr_o  out  ADDR_X  X RAM read address.
- memX_data_i  in  DATA_WIDTH  X RAM read data, valid one cycle after address.
- memY_addr_o  out  ADDR_Y  Y RAM read address.
- memY_data_i  in  DATA_WIDTH  Y RAM read data, valid one cycle after address.
- memZ_we_o  out  1  Z RAM write enable.
- memZ_addr_o  out  ADDR_Z  Z RAM write address.
- memZ_data_o  out  ACC_WIDTH  Z RAM write data.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - State goes to IDLE; all outputs and counters go to 0.
  - No further Z writes occur.
- States: IDLE, INIT, READ, DRAIN, WRITE, DONE.
- IDLE:
  - If start_i=1, latch Nx/Ny and set k=0.
  - Values above 2**ADDR_X (resp. 2**ADDR_Y) clamp to that maximum.
  - If Nx=0 or Ny=0, go to DONE; otherwise go to INIT.
  - start_i in any other state is ignored.
- INIT: acc=0, i=lo=max(0,k-Ny+1), hi=min(k,Nx-1); next state is READ.
- READ:
  - Drive memX_addr_o=i, memY_addr_o=k-i.
  - From the second READ cycle onward, acc += memX_data_i*memY_data_i (the data for the previous address).
  - If i==hi, go to DRAIN; otherwise i++.
- DRAIN: acc += final product; next state is WRITE.
- WRITE:
  - memZ_we_o=1, memZ_addr_o=k, memZ_data_o=acc, for exactly one cycle.
  - If k==Nx+Ny-2, go to DONE; otherwise k++ and go to INIT.
- DONE: done_o=1 for one cycle; next state is IDLE.
- Timing:
  - Each output k costs n_k+3 cycles, where n_k = hi-lo+1.
  - done_o is high in the cycle that begins Nx*Ny+3*(Nx+Ny-1) rising edges after the edge that sampled start_i.
  - Zero-size case: done_o is high in the cycle right after the sampling edge.
- Arithmetic:
  - Unsigned, full-precision products zero-extended to ACC_WIDTH.
  - No saturation; with legal parameters no overflow is possible.
- Output hold rules:
  - memZ_we_o=0 outside WRITE.
  - memX_addr_o and memY_addr_o hold their last value outside READ.
  - memZ_data_o and memZ_addr_o hold their last value when memZ_we_o=0.
- Start may be reasserted in the cycle after DONE (back-to-back runs).

Test Plan:
- Nominal: X=[1,2,3], Y=[1,1], start → four writes Z[0..3]=[1,3,5,3]; done_o asserted 18 edges after start sampled; busy_o high throughout.
- Single sample: Nx=Ny=1, X[0]=0x07, Y[0]=0x09 → one write Z[0]=63; done_o 4 edges after start.
- Max magnitude: Nx=Ny=32, all samples 0xFF → Z[31]=2080800, Z[0]=Z[62]=65025; exactly 63 writes; done_o at edge 1024+189=1213.
- Asymmetric / zero: Nx=4, Ny=1, Y[0]=2, X=[5,6,7,8] → Z=[10,12,14,16]; then Nx=0 → done_o next cycle, no memZ_we_o pulses.
- Reset mid-run: assert rst during READ of k=2 in the nominal case → same-cycle outputs 0, busy_o=0, no write for k=2; a fresh start afterwards reproduces [1,3,5,3].
- Start while busy: pulse start_i with new sizes during READ → ignored; results and done timing match the original run; back-to-back start in the cycle after DONE runs correctly.
